uut_perf_harness: RTL

// - Sits between autotest_module and a unit-under-test (cipher wrapper) in the hardware-performance tops.
// - Latches two operand words, resets the UUT for a programmable number of cycles, then collects
//   NUM_WORDS output words (pulsing next_data between words) into an internal buffer.
// - Measures first-word latency and total run cycles; host reads the results after done.

---
 rtl/uut_perf_harness_if.sv | 24 ++
 rtl/uut_perf_harness.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uut_perf_harness_if.sv
// Harness-to-UUT connection: operands and reset toward the cipher wrapper,
// word-valid and output word back from it.
interface uut_perf_harness_if #(
    parameter int IN1_W = 80,
    parameter int IN2_W = 80,
    parameter int OUT_W = 64
);
    logic             rst_uut;
    logic [IN1_W-1:0] in1_uut;
    logic [IN2_W-1:0] in2_uut;
    logic             next_data;
    logic             end_uut;
    logic [OUT_W-1:0] out_uut;

    modport master (
        output rst_uut, in1_uut, in2_uut, next_data,
        input  end_uut, out_uut
    );

    modport slave (
        input  rst_uut, in1_uut, in2_uut, next_data,
        output end_uut, out_uut
    );
endinterface

// File: rtl/uut_perf_harness.sv
// Performance harness: resets the UUT, collects NUM_WORDS output words and times them.
// Optional per-word watchdog enabled by defining UUT_PERF_TIMEOUT_EN.
module uut_perf_harness #(
    parameter int IN1_W     = 80,
    parameter int IN2_W     = 80,
    parameter int OUT_W     = 64,
    parameter int NUM_WORDS = 4,
    parameter int CNT_W     = 32,
    parameter int RST_CYC   = 2,
    parameter int TIMEOUT   = 2**20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [IN1_W-1:0]             in1_i,
    input  logic [IN2_W-1:0]             in2_i,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout_o,
    output logic [CNT_W-1:0]             latency_o,
    output logic [CNT_W-1:0]             total_o,
    input  logic [$clog2(NUM_WORDS):0]   rd_idx,
    output logic [OUT_W-1:0]             rd_data,
    uut_perf_harness_if.master           uut
);
    localparam int IDX_W = $clog2(NUM_WORDS) + 1;
    localparam int RC_W  = $clog2(RST_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (NUM_WORDS < 1 || NUM_WORDS > 256 || RST_CYC < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("uut_perf_harness: illegal parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [IDX_W-1:0] widx_q, widx_d;
    logic [IN1_W-1:0] in1_q, in1_d;
    logic [IN2_W-1:0] in2_q, in2_d;
    logic             end_q, end_d;
    logic             nd_q, nd_d;
    logic             to_q, to_d;
    logic             cap;
    logic [OUT_W-1:0] buf_q [NUM_WORDS];

`ifdef UUT_PERF_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        tot_d   = tot_q;
        widx_d  = widx_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        end_d   = uut.end_uut;
        nd_d    = 1'b0;
        to_d    = to_q;
        cap     = 1'b0;
`ifdef UUT_PERF_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                    rcnt_d  = RC_W'(RST_CYC - 1);
                    to_d    = 1'b0;
                    lat_d   = '0;
                    tot_d   = '0;
                    widx_d  = '0;
                    in1_d   = in1_i;
                    in2_d   = in2_i;
                end
            end
            S_RESET: begin
                // a level already high at release must not count as a new word
                end_d = 1'b1;
                cnt_d = '0;
`ifdef UUT_PERF_TIMEOUT_EN
                wd_d  = WD_W'(TIMEOUT - 1);
`endif
                if (rcnt_q == '0) state_d = S_RUN;
                else              rcnt_d  = rcnt_q - 1'b1;
            end
            S_RUN: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                cap   = !end_q && uut.end_uut;
                if (cap) begin
                    widx_d = widx_q + 1'b1;
                    if (widx_q == '0) lat_d = cnt_q;
                    tot_d = cnt_q;
`ifdef UUT_PERF_TIMEOUT_EN
                    wd_d  = WD_W'(TIMEOUT - 1);
`endif
                    if (int'(widx_q) + 1 < NUM_WORDS) nd_d    = 1'b1;
                    else                              state_d = S_DONE;
                end
`ifdef UUT_PERF_TIMEOUT_EN
                else if (wd_q == '0) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end else begin
                    wd_d = wd_q - 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rcnt_q  <= '0;
            cnt_q   <= '0;
            lat_q   <= '0;
            tot_q   <= '0;
            widx_q  <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            end_q   <= 1'b1;
            nd_q    <= 1'b0;
            to_q    <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) buf_q[i] <= '0;
`ifdef UUT_PERF_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            tot_q   <= tot_d;
            widx_q  <= widx_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            end_q   <= end_d;
            nd_q    <= nd_d;
            to_q    <= to_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (cap && widx_q == IDX_W'(i)) buf_q[i] <= uut.out_uut;
            end
`ifdef UUT_PERF_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = buf_q[i];
        end
    end

    assign busy          = (state_q == S_RESET) || (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign timeout_o     = to_q;
    assign latency_o     = lat_q;
    assign total_o       = tot_q;
    assign uut.rst_uut   = !((state_q == S_RUN) || (state_q == S_DONE));
    assign uut.in1_uut   = in1_q;
    assign uut.in2_uut   = in2_q;
    assign uut.next_data = nd_q;
endmodule
